// File: rtl/ifetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue_if
//   Bundles the instruction-memory fetch channel, the decode-side handshake
//   and the redirect request of the instruction-fetch front end.
//
//   Signals
//     imem_req     fetch request (always accepted by imem the same cycle)
//     imem_addr    word-aligned fetch address
//     imem_rvalid  in-order response valid
//     imem_rdata   response instruction word
//     instr_valid  head entry valid towards decode
//     instr        head instruction word
//     instr_pc     PC of head instruction
//     instr_ready  decoder accepts head
//     redirect     taken branch/jump, flush and refetch
//     redirect_pc  new fetch PC (low two bits ignored)
//
//   Modports
//     master  the prefetch queue itself
//     slave   the environment (imem + decoder + branch unit)
// ---------------------------------------------------------------------------
interface ifetch_prefetch_queue_if #(
    parameter int unsigned PC_WIDTH = 32
) ();
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;
    logic                instr_valid;
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] instr_pc;
    logic                instr_ready;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue
//   Instruction-fetch front end in front of the decoder. Issues sequential
//   word fetches, buffers returned words together with their PC in a small
//   FIFO and hands them to decode with a valid/ready handshake. A redirect
//   flushes the FIFO and drops every response still in flight.
//
//   Parameters
//     DEPTH     FIFO entries (power of 2, >= 2); also bounds buffered +
//               outstanding fetches
//     PC_WIDTH  width of PC / address values
//     RESET_PC  first fetch address after reset
//
//   Ports
//     clk       clock
//     reset     synchronous active-high reset (overrides every other input)
//     fetch_if  ifetch_prefetch_queue_if.master (imem channel, decode
//               handshake, redirect)
//
//   Configuration macro
//     IFQ_BYPASS_EN  when defined, a response arriving while the FIFO is
//                    empty and decode is ready goes straight to decode in
//                    the same cycle instead of through the FIFO.
// ---------------------------------------------------------------------------
module ifetch_prefetch_queue #(
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    ifetch_prefetch_queue_if.master  fetch_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]    PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]    PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0] PC_STEP  = {{(PC_WIDTH-3){1'b0}}, 3'b100};

    // State registers
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] resp_pc_q,  resp_pc_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [CNT_W-1:0]    outst_q,    outst_d;
    logic [CNT_W-1:0]    discard_q,  discard_d;
    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;

    // FIFO storage
    logic [PC_WIDTH-1:0] mem_pc_q   [DEPTH];
    logic [31:0]         mem_word_q [DEPTH];

    // Control strobes
    logic                issue_s;
    logic                resp_live_s;
    logic                bypass_s;
    logic                push_s;
    logic                pop_s;
    logic [CNT_W-1:0]    occupancy_s;
    logic [PC_WIDTH-1:0] redirect_aligned_s;

    // Buffered entries plus in-flight fetches; never exceeds DEPTH, so it fits CNT_W bits.
    assign occupancy_s        = count_q + outst_q;
    assign redirect_aligned_s = {fetch_if.redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Handshake strobes: issue, live response, bypass, push and pop
    always_comb begin
        issue_s     = 1'b0;
        resp_live_s = 1'b0;
        bypass_s    = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!reset && !fetch_if.redirect) begin
            issue_s     = (occupancy_s < CNT_MAX);
            // A response is kept only while nothing is left to discard.
            resp_live_s = fetch_if.imem_rvalid && (discard_q == CNT_ZERO);
            pop_s       = (count_q != CNT_ZERO) && fetch_if.instr_ready;
`ifdef IFQ_BYPASS_EN
            bypass_s    = resp_live_s && (count_q == CNT_ZERO) && fetch_if.instr_ready;
`else
            bypass_s    = 1'b0;
`endif
            push_s      = resp_live_s && !bypass_s;
        end else begin
            issue_s     = 1'b0;
        end
    end

    // Next-state logic for PCs, counters and FIFO pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fetch_if.redirect) begin
            // Flush: every fetch still in flight is stale; a response landing
            // this very cycle is itself dropped, so it is not counted again.
            fetch_pc_d = redirect_aligned_s;
            resp_pc_d  = redirect_aligned_s;
            count_d    = CNT_ZERO;
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            if (fetch_if.imem_rvalid) begin
                outst_d   = outst_q - CNT_ONE;
                discard_d = outst_q - CNT_ONE;
            end else begin
                outst_d   = outst_q;
                discard_d = outst_q;
            end
        end else begin
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end

            case ({issue_s, fetch_if.imem_rvalid})
                2'b10:   outst_d = outst_q + CNT_ONE;
                2'b01:   outst_d = outst_q - CNT_ONE;
                default: outst_d = outst_q;
            endcase

            if (fetch_if.imem_rvalid && (discard_q != CNT_ZERO)) begin
                discard_d = discard_q - CNT_ONE;
            end else begin
                discard_d = discard_q;
            end

            // resp_pc tracks the PC of the next kept response, bypassed or pushed.
            if (resp_live_s) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end else begin
                resp_pc_d = resp_pc_q;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= CNT_ZERO;
            outst_q    <= CNT_ZERO;
            discard_q  <= CNT_ZERO;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage write; cleared on reset so the head reads 0 / RESET_PC
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= RESET_PC;
                mem_word_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            mem_word_q[wr_ptr_q] <= fetch_if.imem_rdata;
        end else begin
            mem_pc_q[wr_ptr_q]   <= mem_pc_q[wr_ptr_q];
            mem_word_q[wr_ptr_q] <= mem_word_q[wr_ptr_q];
        end
    end

    // Output drive: fetch channel and head-of-queue presentation
    always_comb begin
        fetch_if.imem_req    = issue_s;
        fetch_if.imem_addr   = fetch_pc_q;
        fetch_if.instr_valid = (count_q != CNT_ZERO);
        fetch_if.instr       = mem_word_q[rd_ptr_q];
        fetch_if.instr_pc    = mem_pc_q[rd_ptr_q];
        if (bypass_s) begin
            // Only reachable with IFQ_BYPASS_EN; FIFO is empty in this case.
            fetch_if.instr_valid = 1'b1;
            fetch_if.instr       = fetch_if.imem_rdata;
            fetch_if.instr_pc    = resp_pc_q;
        end else begin
            fetch_if.instr_valid = (count_q != CNT_ZERO);
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch_queue
//   Directed, table-driven bench for ifetch_prefetch_queue (DEPTH=4,
//   RESET_PC=0x100, default build). A small in-order imem model with
//   configurable latency answers every request; the instruction word for an
//   address is word_of(addr), so a misrouted or stale word is visible.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch_queue;
    logic clk;
    logic reset;

    ifetch_prefetch_queue_if #(.PC_WIDTH(32)) bus ();

    ifetch_prefetch_queue #(
        .DEPTH    (4),
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // imem model state
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    int          cyc = 0;
    int          lat = 1;

    // sampled DUT outputs
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and imem response, sample, clock, update model.
    task automatic step(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        reset           = rst;
        bus.instr_ready = rdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(pend_addr[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.instr_valid;
        s_instr = bus.instr;
        s_pc    = bus.instr_pc;
        @(posedge clk);
        if (bus.imem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (s_req) begin
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
        end
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end
        cyc++;
    endtask

    // Wait for instr_valid within a bounded number of cycles; returns cycles taken.
    task automatic wait_valid(input string nm, output int n);
        n = 0;
        s_valid = 1'b0;
        while (!s_valid && n < 20) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            n++;
        end
        check({nm, " valid seen"}, {31'h0, s_valid}, 32'h1);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int n;
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        // Streaming with 1-cycle imem, then reset and a 11-cycle stall + drain
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h100};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h104};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h110, 1'b1, 32'h108};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h114, 1'b1, 32'h10C};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h100};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h100};
        for (int i = 11; i <= 16; i++) begin
            vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h110, 1'b1, 32'h100};
        end
        vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h110, 1'b1, 32'h100};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h110, 1'b1, 32'h104};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h114, 1'b1, 32'h108};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h118, 1'b1, 32'h10C};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h11C, 1'b1, 32'h110};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 32'h114};

        // Reset state
        lat = 1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst instr",    s_instr, 32'h0);
        check("rst instr_pc", s_pc,    32'h100);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc);
            check($sformatf("v%0d imem_req", i),    {31'h0, s_req},   {31'h0, vecs[i].exp_req});
            check($sformatf("v%0d imem_addr", i),   s_addr,           vecs[i].exp_addr);
            check($sformatf("v%0d instr_valid", i), {31'h0, s_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d instr_pc", i), s_pc,    vecs[i].exp_pc);
                check($sformatf("v%0d instr", i),    s_instr, word_of(vecs[i].exp_pc));
            end
        end

        // Redirect with 3 fetches in flight (3-cycle imem); one lands in the redirect cycle
        lat = 3;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3 addr0", s_addr, 32'h100);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3 addr1", s_addr, 32'h104);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3 addr2", s_addr, 32'h108);
        step(1'b0, 1'b1, 1'b1, 32'h203);
        check("t3 redirect req", {31'h0, s_req}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3 req after",  {31'h0, s_req}, 32'h1);
        check("t3 addr after", s_addr, 32'h200);
        check("t3 valid after", {31'h0, s_valid}, 32'h0);
        wait_valid("t3", n);
        check("t3 first pc",   s_pc,    32'h200);
        check("t3 first word", s_instr, word_of(32'h200));
        check("t3 latency",    n,       4);

        // Redirect in the same cycle as rvalid and instr_ready with count=2 (2-cycle imem)
        lat = 2;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b1, 1'b1, 32'h300);
        check("t4 head pc",     s_pc,  32'h100);
        check("t4 redirect req", {31'h0, s_req}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4 flushed",  {31'h0, s_valid}, 32'h0);
        check("t4 addr",     s_addr, 32'h300);
        wait_valid("t4", n);
        check("t4 first pc",   s_pc,    32'h300);
        check("t4 first word", s_instr, word_of(32'h300));
        check("t4 latency",    n,       3);

        // Sequential fetch across the top of the address space
        lat = 1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5 addr FFF8", s_addr, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5 addr FFFC", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5 addr wrap", s_addr, 32'h0000_0000);
        check("t5 pc FFF8",   s_pc,   32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5 pc FFFC",   s_pc,   32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5 pc wrap",   s_pc,    32'h0000_0000);
        check("t5 word wrap", s_instr, word_of(32'h0));

        // Reset mid-stream together with redirect: reset wins
        step(1'b1, 1'b1, 1'b1, 32'h400);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t6 valid",  {31'h0, s_valid}, 32'h0);
        check("t6 addr",   s_addr, 32'h100);
        check("t6 req",    {31'h0, s_req}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t6 addr2",  s_addr, 32'h104);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t6 valid2", {31'h0, s_valid}, 32'h1);
        check("t6 pc",     s_pc,    32'h100);
        check("t6 word",   s_instr, word_of(32'h100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
